if_fetch_sequencer: RTL and testbench
=====================================

Name: if_fetch_sequencer

Overview:
- Control FSM for the instruction-fetch stage.
- Drives the algorithm-address mux select (sel_dir), the PC mux select (sel_pc) and a PC enable (pc_en) so that one cipher algorithm is fetched from instruction ROM once per data block.
- Repeats the algorithm for a requested number of blocks, freezes fetch on the END opcode, drains the downstream pipeline, then reports done.
- Sits between the top-level command interface and the fetch stage.

Parameters:
- OPCODE_END, 4'hF, opcode (instruccion[13:10]) that terminates an algorithm.
- DRAIN_CYCLES, 4, cycles to wait after END so in-flight instructions retire.
- BLK_W, 8, width of the block counter.
- MAX_INSTR, 63, fetched-instruction limit per pass before a runaway error is flagged.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle command pulse; sampled only in IDLE.
- alg_sel, input, 3, algorithm index (0 enc XOR … 7 dec ADD); latched on start.
- num_blocks, input, BLK_W, number of passes; latched on start.
- abort, input, 1, synchronous cancel from any state.
- stall, input, 1, downstream hazard stall.
- instruccion, input, 14, registered ROM output.
- sel_dir, output, 3, algorithm-address mux select.
- sel_pc, output, 1, 1 = load algorithm base address into PC.
- pc_en, output, 1, PC register update enable.
- instr_valid, output, 1, instruccion is a live, issuable instruction this cycle.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at normal completion.
- err, output, 1, sticky runaway flag; cleared by the next accepted start.
- blk_idx, output, BLK_W, index of the block being processed.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal counters 0.
- States: IDLE, LOAD, FILL, RUN, DRAIN, NEXT, DONE.
- IDLE:
  - pc_en=0.
  - On start=1, latch alg_sel and num_blocks, clear err and blk_idx.
  - If num_blocks==0, go to DONE; otherwise go to LOAD.
- LOAD (1 cycle):
  - sel_dir=latched alg, sel_pc=1, pc_en=1, so PC takes the base address at the end of the cycle.
  - Next state FILL.
- FILL (1 cycle):
  - Covers the ROM address-to-q latency.
  - sel_pc=0, pc_en=!stall, instr_valid=0.
  - Stays in FILL while stall=1; otherwise goes to RUN.
- RUN:
  - pc_en=!stall.
  - instr_valid=!stall and opcode!=OPCODE_END.
  - The instruction counter increments on each issued instruction.
  - If opcode==OPCODE_END and stall=0: pc_en=0 this cycle, load the drain counter with DRAIN_CYCLES, go to DRAIN.
  - If the counter reaches MAX_INSTR without END: set err=1, go to IDLE; done is not pulsed.
- DRAIN:
  - pc_en=0, instr_valid=0.
  - Counter decrements each cycle; at 0 go to NEXT.
- NEXT (1 cycle):
  - blk_idx+1.
  - If blk_idx+1==num_blocks, go to DONE; otherwise go to LOAD.
- DONE (1 cycle): done=1, then go to IDLE.
- start while busy: ignored, with no effect on latched values.
- abort: takes precedence over all transitions.
  - Next state IDLE; pc_en, sel_pc and instr_valid forced 0 that cycle.
  - blk_idx is held for debug; done is not pulsed.
- stall and END in the same cycle: END is not acted on; re-evaluated when stall drops.
- sel_dir holds the latched algorithm value in every state except IDLE/reset, where it is 0.
- Output register style: sel_pc, pc_en and instr_valid are combinational from state and inputs; all others are registered.

Decomposition:
- Shared package fetch_pkg:
  - state enum;
  - OPCODE_END;
  - algorithm index constants ALG_ENC_XOR … ALG_DEC_ADD (0–7);
  - opcode field slice positions [13:10].
- No sub-module is needed; the instruction and drain counters are inline, since a separate counter module adds no reuse.

Test Plan:
- Reset mid-RUN: assert rst_n=0 -> all outputs 0 immediately, state IDLE; after release, busy=0 until start.
- start, alg_sel=2, num_blocks=1, END at 4th instruction ->
  - LOAD cycle shows sel_dir=2, sel_pc=1;
  - instr_valid=1 for exactly 3 cycles;
  - DRAIN lasts 4 cycles;
  - done pulses once;
  - blk_idx=1 at done.
- num_blocks=3, alg_sel=6 -> three LOAD cycles (sel_pc pulses 3×), blk_idx steps 0→1→2→3, single done.
- stall=1 for 2 cycles in RUN -> pc_en=0 and instr_valid=0 those cycles; same instruction stays on instruccion; issued count unchanged.
- abort during DRAIN of block 1 of 3 -> next cycle IDLE, busy=0, no done pulse; a new start (alg 4, num_blocks 1) then runs normally.
- No END within 63 instructions -> err=1, busy=0, no done; err clears on the next start.
- num_blocks=0 -> busy high for 1 cycle (DONE), done=1, sel_pc never asserted.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states,
// the terminating opcode, algorithm indices and the opcode field position.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } fetch_state_e;

    // Opcode that terminates an algorithm in instruction ROM.
    localparam logic [3:0] OPCODE_END = 4'hF;

    // Opcode field inside the 14-bit instruction word.
    localparam int OPC_MSB = 13;
    localparam int OPC_LSB = 10;

    // Algorithm indices as presented on alg_sel / sel_dir.
    localparam logic [2:0] ALG_ENC_XOR = 3'd0;
    localparam logic [2:0] ALG_ENC_ROT = 3'd1;
    localparam logic [2:0] ALG_ENC_SUB = 3'd2;
    localparam logic [2:0] ALG_ENC_ADD = 3'd3;
    localparam logic [2:0] ALG_DEC_XOR = 3'd4;
    localparam logic [2:0] ALG_DEC_ROT = 3'd5;
    localparam logic [2:0] ALG_DEC_SUB = 3'd6;
    localparam logic [2:0] ALG_DEC_ADD = 3'd7;

    // Extract the opcode field from an instruction word.
    function automatic logic [3:0] opcode_of(input logic [13:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/if_fetch_sequencer.sv
// Instruction-fetch control FSM: loads the algorithm base address, lets the
// ROM latency elapse, issues instructions until END, drains the pipeline and
// repeats once per data block before reporting done.
module if_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int BLK_W        = 8,
    parameter int MAX_INSTR    = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alg_sel,
    input  logic [BLK_W-1:0] num_blocks,
    input  logic             abort,
    input  logic             stall,
    input  logic [13:0]      instruccion,
    output logic [2:0]       sel_dir,
    output logic             sel_pc,
    output logic             pc_en,
    output logic             instr_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BLK_W-1:0] blk_idx
);

    localparam int ICNT_W = $clog2(MAX_INSTR + 1);
    localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);

    fetch_state_e      state_q, state_d;
    logic [2:0]        alg_q, alg_d;
    logic [BLK_W-1:0]  nblk_q, nblk_d;
    logic [BLK_W-1:0]  blk_idx_q, blk_idx_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [2:0]        sel_dir_q, sel_dir_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              is_end;

    assign is_end = (opcode_of(instruccion) == OPCODE_END);

    // Next-state, counter and combinational fetch-control decode.
    always_comb begin
        state_d     = state_q;
        alg_d       = alg_q;
        nblk_d      = nblk_q;
        blk_idx_d   = blk_idx_q;
        icnt_d      = icnt_q;
        dcnt_d      = dcnt_q;
        err_d       = err_q;
        sel_pc      = 1'b0;
        pc_en       = 1'b0;
        instr_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    alg_d     = alg_sel;
                    nblk_d    = num_blocks;
                    err_d     = 1'b0;
                    blk_idx_d = '0;
                    state_d   = (num_blocks == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                sel_pc  = 1'b1;
                pc_en   = 1'b1;
                icnt_d  = '0;
                state_d = ST_FILL;
            end
            ST_FILL: begin
                // PC advances only once the ROM has captured the base address.
                pc_en = !stall;
                if (!stall) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A stalled END is not acted on; it is re-evaluated next cycle.
                if (!stall) begin
                    if (is_end) begin
                        dcnt_d  = DCNT_W'(DRAIN_CYCLES);
                        state_d = ST_DRAIN;
                    end else begin
                        pc_en       = 1'b1;
                        instr_valid = 1'b1;
                        icnt_d      = icnt_q + 1'b1;
                        if (icnt_d == ICNT_W'(MAX_INSTR)) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                dcnt_d = dcnt_q - 1'b1;
                if (dcnt_d == '0) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                blk_idx_d = blk_idx_q + 1'b1;
                state_d   = (blk_idx_d == nblk_q) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition; block index is kept for debug.
        if (abort) begin
            state_d     = ST_IDLE;
            alg_d       = alg_q;
            nblk_d      = nblk_q;
            blk_idx_d   = blk_idx_q;
            err_d       = err_q;
            sel_pc      = 1'b0;
            pc_en       = 1'b0;
            instr_valid = 1'b0;
        end

        sel_dir_d = (state_d != ST_IDLE) ? alg_d : 3'd0;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            alg_q     <= '0;
            nblk_q    <= '0;
            blk_idx_q <= '0;
            icnt_q    <= '0;
            dcnt_q    <= '0;
            sel_dir_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            alg_q     <= alg_d;
            nblk_q    <= nblk_d;
            blk_idx_q <= blk_idx_d;
            icnt_q    <= icnt_d;
            dcnt_q    <= dcnt_d;
            sel_dir_q <= sel_dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sel_dir = sel_dir_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign blk_idx = blk_idx_q;

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Bench for if_fetch_sequencer: a ROM model reacts to the PC controls, and an
// expected per-cycle timeline is generated from the block/instruction script.
module tb_if_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  alg_sel = '0;
    logic [7:0]  num_blocks = '0;
    logic        abort = 1'b0;
    logic        stall = 1'b0;
    logic [13:0] instruccion;
    logic [2:0]  sel_dir;
    logic        sel_pc, pc_en, instr_valid, busy, done, err;
    logic [7:0]  blk_idx;

    int errors = 0;
    int checks = 0;
    int stall_pct = 0;
    int consec = 0;

    if_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alg_sel(alg_sel),
        .num_blocks(num_blocks), .abort(abort), .stall(stall),
        .instruccion(instruccion), .sel_dir(sel_dir), .sel_pc(sel_pc),
        .pc_en(pc_en), .instr_valid(instr_valid), .busy(busy), .done(done),
        .err(err), .blk_idx(blk_idx)
    );

    always #5 clk = ~clk;

    // Instruction ROM with registered output; PC and q advance with pc_en.
    logic [13:0] rom [0:1023];
    int          pc_m;
    logic [13:0] q_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_m <= 0;
            q_m  <= '0;
        end else if (pc_en) begin
            q_m  <= rom[pc_m];
            pc_m <= sel_pc ? int'(sel_dir) * 64 : pc_m + 1;
        end
    end
    assign instruccion = q_m;

    typedef struct packed {
        logic       stl;
        logic [2:0] sd;
        logic       sp;
        logic       pe;
        logic       iv;
        logic       dn;
        logic       bz;
        logic [7:0] blk;
        logic       er;
    } exp_t;

    exp_t tq[$];

    function automatic logic rs();
        if (consec >= 3 || $urandom_range(99) >= stall_pct) begin
            consec = 0;
            return 1'b0;
        end
        consec++;
        return 1'b1;
    endfunction

    function automatic void push(logic stl, logic [2:0] sd, logic sp, logic pe,
                                 logic iv, logic dn, logic bz, int blk, logic er);
        exp_t e;
        e.stl = stl; e.sd = sd; e.sp = sp; e.pe = pe; e.iv = iv;
        e.dn = dn; e.bz = bz; e.blk = 8'(blk); e.er = er;
        tq.push_back(e);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_entry(input exp_t e, input string tag);
        chk({tag, " sel_dir"}, 32'(sel_dir), 32'(e.sd));
        chk({tag, " sel_pc"}, 32'(sel_pc), 32'(e.sp));
        chk({tag, " pc_en"}, 32'(pc_en), 32'(e.pe));
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(e.iv));
        chk({tag, " busy"}, 32'(busy), 32'(e.bz));
        chk({tag, " done"}, 32'(done), 32'(e.dn));
        chk({tag, " blk_idx"}, 32'(blk_idx), 32'(e.blk));
        chk({tag, " err"}, 32'(err), 32'(e.er));
    endtask

    // Place an algorithm with END at offset k (k > 62 means no END at all).
    task automatic prog(input logic [2:0] alg, input int k);
        for (int i = 0; i < 64; i++)
            rom[int'(alg) * 64 + i] = {4'($urandom_range(14)), 10'($urandom)};
        if (k <= 62) rom[int'(alg) * 64 + k][13:10] = OPCODE_END;
    endtask

    // Expected cycle timeline starting the cycle after the accepted start.
    task automatic build(input logic [2:0] alg, input int nb, input int k,
                         output int dmark, output int rmark);
        logic s;
        tq.delete();
        dmark = -1;
        rmark = -1;
        for (int b = 0; b < nb; b++) begin
            push(rs(), alg, 1, 1, 0, 0, 1, b, 0);                  // base load
            do begin s = rs(); push(s, alg, 0, !s, 0, 0, 1, b, 0); end while (s);
            if (b == 0) rmark = tq.size() + 1;
            if (k > 62) begin
                for (int i = 0; i < 63; i++)
                    do begin s = rs(); push(s, alg, 0, !s, !s, 0, 1, b, 0); end while (s);
                push(0, 3'd0, 0, 0, 0, 0, 0, b, 1);                // runaway stop
                return;
            end
            for (int i = 0; i < k; i++)
                do begin s = rs(); push(s, alg, 0, !s, !s, 0, 1, b, 0); end while (s);
            do begin s = rs(); push(s, alg, 0, 0, 0, 0, 1, b, 0); end while (s); // END
            if (b == 1) dmark = tq.size() + 1;
            repeat (4) push(rs(), alg, 0, 0, 0, 0, 1, b, 0);       // drain
            push(rs(), alg, 0, 0, 0, 0, 1, b, 0);                  // block step
        end
        push(0, alg, 0, 0, 0, 1, 1, nb, 0);                        // done pulse
        push(0, 3'd0, 0, 0, 0, 0, 0, nb, 0);                       // back to idle
    endtask

    // mode 0: plain, 1: abort at idx, 2: async reset at idx.
    task automatic job(input logic [2:0] alg, input int nb, input int k, input int mode);
        int dmark, rmark, idx;
        exp_t e;
        prog(alg, k);
        build(alg, nb, k, dmark, rmark);
        idx = (mode == 1) ? dmark : (mode == 2) ? rmark : -1;
        start = 1'b1; alg_sel = alg; num_blocks = 8'(nb); stall = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_cycle busy", 32'(busy), 0);
        chk("start_cycle sel_pc", 32'(sel_pc), 0);
        @(posedge clk); #1;
        for (int t = 0; t < tq.size(); t++) begin
            e = tq[t];
            stall = e.stl;
            abort = (t == idx) && (mode == 1);
            if (e.bz) begin
                start = ($urandom_range(7) == 0);
                alg_sel = 3'($urandom);
                num_blocks = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            if (mode == 2 && t == idx) begin
                #2 rst_n = 1'b0;
                #1;
                e.sd = 0; e.sp = 0; e.pe = 0; e.iv = 0; e.dn = 0; e.bz = 0; e.blk = 0; e.er = 0;
                chk_entry(e, $sformatf("reset_mid_run t=%0d", t));
                start = 1'b0; stall = 1'b0;
                @(negedge clk); rst_n = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk("after_reset busy", 32'(busy), 0);
                    chk("after_reset pc_en", 32'(pc_en), 0);
                end
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (abort) begin
                e.sp = 0; e.pe = 0; e.iv = 0;
                chk_entry(e, $sformatf("abort_cycle t=%0d", t));
                @(posedge clk); #1;
                abort = 1'b0; start = 1'b0; stall = 1'b0;
                e.sd = 0; e.bz = 0; e.dn = 0;
                @(negedge clk);
                chk_entry(e, "after_abort");
                @(posedge clk); #1;
                return;
            end
            chk_entry(e, $sformatf("alg%0d nb%0d k%0d t=%0d", alg, nb, k, t));
            @(posedge clk); #1;
        end
        start = 1'b0;
        stall = 1'b0;
        $display("job alg=%0d blocks=%0d end_at=%0d mode=%0d cycles=%0d errors=%0d",
                 alg, nb, k, mode, tq.size(), errors);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        for (int i = 0; i < 1024; i++) rom[i] = {4'($urandom_range(14)), 10'($urandom)};
        z = '0;
        repeat (2) @(negedge clk);
        chk_entry(z, "reset_state");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset busy", 32'(busy), 0);
        @(posedge clk); #1;

        stall_pct = 0;
        job(ALG_ENC_SUB, 1, 3, 0);     // END at 4th instruction, no stalls
        job(ALG_DEC_SUB, 3, 5, 0);     // three blocks
        stall_pct = 40;
        job(ALG_ENC_ROT, 2, 6, 0);     // stalls in FILL/RUN
        stall_pct = 20;
        job(ALG_DEC_ADD, 3, 4, 1);     // abort during drain of block 1
        job(ALG_DEC_XOR, 1, 2, 0);     // runs normally after abort
        job(ALG_ENC_ADD, 2, 100, 0);   // runaway, err set
        job(ALG_ENC_XOR, 1, 1, 0);     // err cleared by new start
        job(ALG_DEC_ROT, 0, 0, 0);     // zero blocks
        job(ALG_ENC_ROT, 2, 5, 2);     // async reset mid-run
        for (int r = 0; r < 6; r++)
            job(3'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 10)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
